// File: rtl/tile_update_ctrl.sv
// Tile update controller: one read-evaluate-write pass on the map tile under the player per frame_tick.
// Define SCORE_BCD_EN for a 3-digit BCD score (saturating at 999); the default build keeps a binary score saturating at 1023.
module tile_update_ctrl #(
  parameter int TILE_PX  = 40,
  parameter int MAP_COLS = 16,
  parameter int MAP_ROWS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  player_xpos,
  input  logic [8:0]  player_ypos,
  input  logic        direction,
  input  logic        up_direction,
  input  logic        map_busy,
  input  logic [5:0]  map_rd_data,
  output logic [7:0]  map_addr,
  output logic        map_we,
  output logic [5:0]  map_wr_data,
  output logic [11:0] score,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, EVAL, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_q;
  logic        in_half_q, up_q, in_range_q, point_q;
  logic [5:0]  tile_q, wr_code_q;
  logic [11:0] score_q;
  logic        overrun_q;

  logic [9:0]  col_calc, rel_calc;
  logic [8:0]  row_calc;
  logic [7:0]  addr_calc;
  logic        in_range_calc, in_half_calc;
  logic        eval_write, eval_point;
  logic [5:0]  eval_code;

  // Tile coordinates are derived at the tick so the pass never depends on later input changes.
  always_comb begin
    col_calc      = 10'(32'(player_xpos) / TILE_PX);
    rel_calc      = 10'(32'(player_xpos) % TILE_PX);
    row_calc      = 9'(32'(player_ypos) / TILE_PX);
    addr_calc     = 8'(32'(row_calc) * MAP_COLS + 32'(col_calc));
    in_range_calc = (32'(col_calc) < MAP_COLS) && (32'(row_calc) < MAP_ROWS);
    in_half_calc  = direction ? (32'(rel_calc) >= TILE_PX / 2) : (32'(rel_calc) < TILE_PX / 2);
  end

`ifdef SCORE_BCD_EN
  function automatic logic [11:0] score_inc(input logic [11:0] s);
    logic [3:0] d0, d1, d2;
    d0 = s[3:0];
    d1 = s[7:4];
    d2 = s[11:8];
    if (s == 12'h999) return s;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction
`else
  function automatic logic [11:0] score_inc(input logic [11:0] s);
    if (s >= 12'd1023) return 12'd1023;
    return s + 12'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      in_half_q  <= 1'b0;
      up_q       <= 1'b0;
      in_range_q <= 1'b0;
      tile_q     <= '0;
      wr_code_q  <= '0;
      point_q    <= 1'b0;
      score_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && frame_tick) begin
        addr_q     <= addr_calc;
        in_half_q  <= in_half_calc;
        up_q       <= up_direction;
        in_range_q <= in_range_calc;
      end
      if (state != IDLE && frame_tick) overrun_q <= 1'b1;
      if (state == WAIT) tile_q <= map_rd_data;
      if (state == EVAL) begin
        wr_code_q <= eval_code;
        point_q   <= eval_point;
      end
      if (state == WRITE && !map_busy && point_q) score_q <= score_inc(score_q);
    end
  end

  // Outputs are forced to their idle values while rst is high so an in-flight write is suppressed.
  always_comb begin
    state_nxt   = state;
    map_addr    = '0;
    map_we      = 1'b0;
    map_wr_data = '0;
    eval_write  = 1'b0;
    eval_point  = 1'b0;
    eval_code   = '0;
    case (tile_q)
      6'd28: begin eval_write = 1'b1; eval_point = 1'b1; eval_code = 6'd0; end
      6'd3:  if (in_half_q && up_q) begin eval_write = 1'b1; eval_point = 1'b1; eval_code = 6'd34; end
      6'd9:  if (in_half_q && up_q) begin eval_write = 1'b1; eval_code = 6'd0; end
      default: ;
    endcase
    case (state)
      IDLE:  if (frame_tick) state_nxt = ADDR;
      ADDR: begin
        if (!in_range_q) state_nxt = DONE;
        else if (!map_busy) begin
          map_addr  = addr_q;
          state_nxt = WAIT;
        end
      end
      WAIT:  state_nxt = EVAL;
      EVAL:  state_nxt = eval_write ? WRITE : DONE;
      WRITE: if (!map_busy) begin
        map_addr    = addr_q;
        map_we      = 1'b1;
        map_wr_data = wr_code_q;
        state_nxt   = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy    = (state != IDLE);
    done    = (state == DONE);
    score   = score_q;
    overrun = overrun_q;
    if (rst) begin
      map_addr    = '0;
      map_we      = 1'b0;
      map_wr_data = '0;
      busy        = 1'b0;
      done        = 1'b0;
      score       = '0;
      overrun     = 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_update_ctrl.sv
// Scoreboard bench for tile_update_ctrl: directed passes push expected results, a monitor checks each done pulse.
// Honours SCORE_BCD_EN the same way as the design.
module tb_tile_update_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [9:0]  player_xpos = '0;
  logic [8:0]  player_ypos = '0;
  logic        direction = 1'b0;
  logic        up_direction = 1'b0;
  logic        map_busy = 1'b0;
  logic [5:0]  map_rd_data;
  logic [7:0]  map_addr;
  logic        map_we;
  logic [5:0]  map_wr_data;
  logic [11:0] score;
  logic        busy, done, overrun;

  typedef struct {
    int          lat;
    int          writes;
    logic [7:0]  addr;
    logic [5:0]  data;
    logic [11:0] score;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tickCyc = 0;
  int          wrCnt = 0;
  logic [7:0]  wrAddrSeen;
  logic [5:0]  wrDataSeen;
  logic        doneSeen = 1'b0;
  logic [11:0] expScore = '0;
  logic        preEn = 1'b0;
  logic [7:0]  preAddr = '0;
  logic [5:0]  preData = '0;
  logic [5:0]  mem [0:255] = '{default: 6'd5};

`ifdef SCORE_BCD_EN
  localparam logic [11:0] SCORE_MAX = 12'h999;
`else
  localparam logic [11:0] SCORE_MAX = 12'd1023;
`endif

  tile_update_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .player_xpos(player_xpos), .player_ypos(player_ypos),
    .direction(direction), .up_direction(up_direction),
    .map_busy(map_busy), .map_rd_data(map_rd_data),
    .map_addr(map_addr), .map_we(map_we), .map_wr_data(map_wr_data),
    .score(score), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Map RAM model with one-cycle read latency; preload port lets stimulus place a tile.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preEn) mem[preAddr] <= preData;
    else if (map_we) mem[map_addr] <= map_wr_data;
    map_rd_data <= mem[map_addr];
  end

  function automatic logic [11:0] nextScore(input logic [11:0] s);
`ifdef SCORE_BCD_EN
    int v;
    v = int'(s[11:8]) * 100 + int'(s[7:4]) * 10 + int'(s[3:0]);
    if (v < 999) v = v + 1;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return (s == 12'd1023) ? s : s + 12'd1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse and guards against writes during map_busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (map_busy) checkOutput("we_while_busy", {31'd0, map_we}, 32'd0);
      if (map_we) begin
        wrCnt++;
        wrAddrSeen = map_addr;
        wrDataSeen = map_wr_data;
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("done_latency", 32'(cyc - tickCyc), 32'(e.lat));
          checkOutput("write_count", 32'(wrCnt), 32'(e.writes));
          if (e.writes == 1) begin
            checkOutput("write_addr", {24'd0, wrAddrSeen}, {24'd0, e.addr});
            checkOutput("write_data", {26'd0, wrDataSeen}, {26'd0, e.data});
          end
          checkOutput("score", {20'd0, score}, {20'd0, e.score});
        end
        wrCnt = 0;
        doneSeen = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic dir, input logic up,
                               input logic [7:0] addr, input logic [5:0] tile, input int lat,
                               input int writes, input logic [5:0] wdata, input logic point,
                               input logic [15:0] busyMask, input int extraTick);
    exp_t e;
    @(posedge clk); #1;
    preEn = 1'b1; preAddr = addr; preData = tile;
    @(posedge clk); #1;
    preEn = 1'b0;
    if (point) expScore = nextScore(expScore);
    e.lat = lat; e.writes = writes; e.addr = addr; e.data = wdata; e.score = expScore;
    expQ.push_back(e);
    player_xpos = x; player_ypos = y; direction = dir; up_direction = up;
    frame_tick = 1'b1; map_busy = busyMask[0];
    tickCyc = cyc; doneSeen = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      frame_tick = (i == extraTick);
      map_busy = busyMask[i];
      if (i == 1) begin
        player_xpos = ~x; player_ypos = ~y; direction = ~dir; up_direction = ~up;
      end
    end
    map_busy = 1'b0;
    for (int k = 0; k < 20 && !doneSeen; k++) @(posedge clk);
    if (!doneSeen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      expQ.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_map_we"}, {31'd0, map_we}, 32'd0);
    checkOutput({tag, "_map_addr"}, {24'd0, map_addr}, 32'd0);
    checkOutput({tag, "_map_wr_data"}, {26'd0, map_wr_data}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_score"}, {20'd0, score}, 32'd0);
    checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // x=85,y=50 -> col 2, row 1, rel 5, addr 18.
    applyStimulus(10'd85, 9'd50, 1'b0, 1'b1, 8'd18, 6'd3, 5, 1, 6'd34, 1'b1, 16'h0, -1);
    applyStimulus(10'd85, 9'd50, 1'b1, 1'b1, 8'd18, 6'd3, 4, 0, 6'd0, 1'b0, 16'h0, -1);
    // x=300,y=400 -> addr 167; tile 28 scores regardless of half/up.
    applyStimulus(10'd300, 9'd400, 1'b1, 1'b0, 8'd167, 6'd28, 5, 1, 6'd0, 1'b1, 16'h0, -1);
    // x=130,y=90 -> addr 35, rel 10.
    applyStimulus(10'd130, 9'd90, 1'b0, 1'b1, 8'd35, 6'd9, 5, 1, 6'd0, 1'b0, 16'h0, -1);
    applyStimulus(10'd130, 9'd90, 1'b0, 1'b0, 8'd35, 6'd9, 4, 0, 6'd0, 1'b0, 16'h0, -1);
    applyStimulus(10'd130, 9'd90, 1'b0, 1'b0, 8'd35, 6'd3, 4, 0, 6'd0, 1'b0, 16'h0, -1);
    // Half boundary: rel 20 is the right half, rel 19 is not.
    applyStimulus(10'd60, 9'd0, 1'b1, 1'b1, 8'd1, 6'd3, 5, 1, 6'd34, 1'b1, 16'h0, -1);
    applyStimulus(10'd59, 9'd0, 1'b1, 1'b1, 8'd1, 6'd3, 4, 0, 6'd0, 1'b0, 16'h0, -1);
    // Last tile of the map, then both out-of-range edges.
    applyStimulus(10'd639, 9'd479, 1'b0, 1'b0, 8'd191, 6'd28, 5, 1, 6'd0, 1'b1, 16'h0, -1);
    applyStimulus(10'd650, 9'd50, 1'b0, 1'b1, 8'd0, 6'd28, 2, 0, 6'd0, 1'b0, 16'h0, -1);
    applyStimulus(10'd85, 9'd480, 1'b0, 1'b1, 8'd0, 6'd28, 2, 0, 6'd0, 1'b0, 16'h0, -1);

    // Stalls: busy in cycles 1-3 (ADDR) and 7-8 (WRITE), extra tick at cycle 5.
    applyStimulus(10'd85, 9'd50, 1'b0, 1'b1, 8'd18, 6'd3, 10, 1, 6'd34, 1'b1, 16'b0000_0001_1000_1110, 5);
    @(negedge clk);
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);

    // Reset asserted during the WRITE cycle of a scoring pass.
    @(posedge clk); #1;
    preEn = 1'b1; preAddr = 8'd18; preData = 6'd3;
    @(posedge clk); #1;
    preEn = 1'b0;
    player_xpos = 10'd85; player_ypos = 9'd50; direction = 1'b0; up_direction = 1'b1;
    frame_tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("rst_in_write");
    @(posedge clk); #1;
    rst = 1'b0;
    expScore = '0;
    @(negedge clk);
    checkOutput("rst_no_write", {26'd0, mem[18]}, 32'd3);
    checkOutput("rst_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("rst_overrun_clr", {31'd0, overrun}, 32'd0);
    applyStimulus(10'd85, 9'd50, 1'b0, 1'b1, 8'd18, 6'd3, 5, 1, 6'd34, 1'b1, 16'h0, -1);

    // Drive the score to its ceiling, then confirm it holds.
    while (expScore != SCORE_MAX)
      applyStimulus(10'd300, 9'd400, 1'b0, 1'b0, 8'd167, 6'd28, 5, 1, 6'd0, 1'b1, 16'h0, -1);
    applyStimulus(10'd300, 9'd400, 1'b0, 1'b0, 8'd167, 6'd28, 5, 1, 6'd0, 1'b1, 16'h0, -1);
    applyStimulus(10'd300, 9'd400, 1'b0, 1'b0, 8'd167, 6'd28, 5, 1, 6'd0, 1'b1, 16'h0, -1);
    @(negedge clk);
    checkOutput("score_saturated", {20'd0, score}, {20'd0, SCORE_MAX});

    repeat (3) @(posedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
